mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the CPU's instruction-fetch requester and its load/store requester.
- Accepts one request per transaction and issues it to memory, then waits out the memory latency and returns a response to the request's owner.
- Data requests have priority over fetch. A burst counter stops back-to-back data accesses from starving fetch.
- Sits between cpu_top's fetch/store signals and the unified memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte-enable width is DATA_W/8).
- MEM_LAT, 1, number of cycles from mem_en to valid mem_rdata; must be at least 1.
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch is waiting; must be at least 1.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted (one-cycle pulse).
- if_rvalid  out  1  fetch response valid (one-cycle pulse).
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with d_* until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted (one-cycle pulse).
- d_rvalid  out  1  load data or store acknowledge (one-cycle pulse).
- d_rdata  out  DATA_W  load data; 0 for a store.
- mem_en  out  1  memory access strobe (one cycle).
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Clock and reset: one clock, CLOCK; reset is asynchronous and active-high on RESET.
- Reset values: every output is 0, the state is IDLE, the owner is NONE, and burst_cnt is 0.
- State machine states: IDLE, ISSUE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - if_gnt and d_gnt are combinational in IDLE only, and at most one is asserted.
  - The winner is latched into owner, the request fields are registered, and the state moves to ISSUE.
  - With no request pending, the state stays IDLE.
- Winner select:
  - If d_req is high and not (if_req high and burst_cnt == MAX_DATA_BURST), data wins.
  - Otherwise, if if_req is high, fetch wins.
- burst_cnt:
  - Increments, saturating at MAX_DATA_BURST, on a data grant while if_req is high.
  - Clears on any fetch grant.
  - Is unchanged on a data grant while if_req is low.
- ISSUE:
  - mem_en is 1 for this cycle, driven from registered mem_* outputs.
  - For fetch: mem_we=0, mem_be=all ones, mem_wdata=0.
  - mem_addr has bits [1:0] forced to 0 for both requesters.
  - Load cnt = MEM_LAT-1, then go to WAIT.
  - mem_* fields other than mem_en hold their values until the next ISSUE.
- WAIT: decrement cnt each cycle. When cnt == 0, capture mem_rdata and go to RESP.
- RESP:
  - The owner's rvalid is 1 for exactly one cycle, with rdata registered.
  - For a store, d_rdata=0.
  - Go to IDLE, owner=NONE.
- Latency (grant at cycle T): mem_en at T+1, mem_rdata sampled at T+1+MEM_LAT, rvalid at T+2+MEM_LAT. The earliest next grant is at T+3+MEM_LAT.
- Simultaneous events:
  - A request arriving during ISSUE, WAIT or RESP is not granted; it waits for IDLE.
  - A request deasserted before its grant is legal and is dropped silently.
- Reset mid-operation: all state and outputs clear immediately. The in-flight transaction gets no rvalid, and the memory access already issued is abandoned.
- The non-owner's rvalid is never asserted.
- Assertions:
  - if_gnt and d_gnt are never both high.
  - rvalid count equals grant count between resets.

Decomposition:
- Add to typePack:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - arb_owner_t enum {NONE, FETCH, DATA}.
- One sub-module, mem_arb_pick:
  - Combinational winner select plus the burst_cnt register.
  - Inputs: if_req, d_req, state==IDLE.
  - Outputs: grant_if, grant_d.
  - Keeps the priority policy testable on its own.
- All counters are sized with $clog2 of their parameter.

Test Plan (MEM_LAT=1, MAX_DATA_BURST=4 unless stated):
- Fetch only: if_addr=0x100 with mem returning 0x00000013 -> if_gnt at T, mem_en with mem_addr=0x100 and mem_we=0 at T+1, if_rvalid with if_rdata=0x00000013 at T+3, d_rvalid stays 0.
- Simultaneous: store d_addr=0x200, d_wdata=0xDEADBEEF, d_be=1111 plus if_req=0x104 in the same cycle -> d_gnt first, mem_we=1 and mem_wdata=0xDEADBEEF, d_rvalid with d_rdata=0; then if_gnt at T+4.
- Starvation: d_req and if_req held high continuously -> exactly 4 d_gnt, then if_gnt, then burst_cnt reads 0 and data wins again.
- Reset mid-WAIT (MEM_LAT=3): assert RESET at T+2 -> all outputs 0 immediately, no rvalid; after release, a fetch at 0x0 completes with rvalid at T'+5.
- Alignment: if_addr=0x103 -> mem_addr=0x100; d_addr=0x206 with d_be=1100 -> mem_addr=0x204 and mem_be=1100.
- Back-to-back loads: two loads of mem words 0x11111111 and 0x22222222 -> d_rvalid pulses 4 cycles apart carrying the matching data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        FETCH,
        DATA
    } arb_owner_t;

    // Width for a down-counter that must hold values 0..n-1 (never zero bits wide).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters, with the burst counter
// that lets fetch in after MAX_DATA_BURST data grants made while it waited.
module mem_arb_pick #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic if_req,
    input  logic d_req,
    input  logic idle,
    output logic grant_if,
    output logic grant_d
);

    localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

    logic [BURST_W-1:0] burst_cnt;
    logic               fetch_starved;

    assign fetch_starved = if_req && (burst_cnt == BURST_MAX);

    // Data has priority unless fetch has been passed over too many times.
    always_comb begin
        grant_d  = idle && d_req && !fetch_starved;
        grant_if = idle && if_req && !(d_req && !fetch_starved);
    end

    // Count data grants taken while fetch was waiting; a fetch grant resets the streak.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            burst_cnt <= '0;
        end else if (grant_if) begin
            burst_cnt <= '0;
        end else if (grant_d && if_req && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// load/store. One transaction in flight at a time: grant, issue, wait, respond.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LAT        = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0]  LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    // Word alignment: the memory never sees byte offsets.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    arb_state_t       state_reg;
    arb_owner_t       owner_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pick_idle;

    // Grants are gated off during reset so every output reads 0 while RESET is high.
    assign pick_idle = (state_reg == IDLE) && !RESET;

    mem_arb_pick #(
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) u_pick (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .if_req   (if_req),
        .d_req    (d_req),
        .idle     (pick_idle),
        .grant_if (if_gnt),
        .grant_d  (d_gnt)
    );

    // Transaction sequencer: latch the winner, strobe memory, count out latency, respond.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
            owner_reg <= NONE;
            cnt_reg   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (d_gnt) begin
                        owner_reg <= DATA;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_addr  <= d_addr & ALIGN_MASK;
                        mem_wdata <= d_wdata;
                        state_reg <= ISSUE;
                    end else if (if_gnt) begin
                        owner_reg <= FETCH;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= '1;
                        mem_addr  <= if_addr & ALIGN_MASK;
                        mem_wdata <= '0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    cnt_reg   <= LAT_LOAD;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                        if (owner_reg == FETCH) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_we ? '0 : mem_rdata;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if_rvalid <= 1'b0;
                    d_rvalid  <= 1'b0;
                    owner_reg <= NONE;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Only one requester may ever be granted in a cycle.
    gnt_onehot: assert property (@(posedge CLOCK) disable iff (RESET) !(if_gnt && d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbitration and memory.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 3;
    localparam int MAXB    = 4;

    logic        CLOCK, RESET;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(
        .ADDR_W (32), .DATA_W (32), .MEM_LAT (MEM_LAT), .MAX_DATA_BURST (MAXB)
    ) dut (
        .CLOCK (CLOCK), .RESET (RESET),
        .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt),
        .if_rvalid (if_rvalid), .if_rdata (if_rdata),
        .d_req (d_req), .d_we (d_we), .d_be (d_be), .d_addr (d_addr),
        .d_wdata (d_wdata), .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
        .mem_en (mem_en), .mem_we (mem_we), .mem_be (mem_be), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
    );

    typedef struct {int cyc; logic is_d; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} mem_exp_t;
    typedef struct {int cyc; logic is_d; logic [31:0] data;} resp_exp_t;

    mem_exp_t    mem_q[$];
    resp_exp_t   resp_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] dev_mem   [256];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, free_cyc = 0, burst = 0, n_gnt = 0, n_rv = 0;
    int          rd_due = -1;
    logic [31:0] rd_word = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    initial begin
        CLOCK = 0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial forever begin
        @(posedge CLOCK);
        cyc++;
    end

    // Memory device: returns read data exactly MEM_LAT cycles after mem_en, junk otherwise.
    initial begin
        mem_rdata = 0;
        forever begin
            @(posedge CLOCK);
            #1;
            mem_rdata = (cyc == rd_due) ? rd_word : $urandom;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: predicts grants, scoreboards memory accesses and responses.
    initial begin : monitor
        int cur, idx;
        bit exp_i, exp_d;
        mem_exp_t me;
        resp_exp_t re;
        logic [31:0] rd, dsel;
        forever begin
            @(negedge CLOCK);
            cur = cyc;
            if (RESET) begin
                check("reset_outputs_zero",
                      {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be,
                       mem_addr, mem_wdata, if_rdata, d_rdata}, '0);
                mem_q.delete();
                resp_q.delete();
                free_cyc = 0; burst = 0; n_gnt = 0; n_rv = 0; rd_due = -1;
                continue;
            end
            exp_d = (cur >= free_cyc) && d_req && !(if_req && burst == MAXB);
            exp_i = (cur >= free_cyc) && if_req && !exp_d;
            check("grant", {if_gnt, d_gnt}, {exp_i, exp_d});
            if (if_gnt || d_gnt) n_gnt++;
            if (exp_d) begin
                mem_q.push_back('{cur + 1, 1'b1, d_we, d_be, d_addr - d_addr % 4, d_wdata});
                if (if_req && burst < MAXB) burst++;
                free_cyc = cur + 3 + MEM_LAT;
            end else if (exp_i) begin
                mem_q.push_back('{cur + 1, 1'b0, 1'b0, 4'hF, if_addr - if_addr % 4, 32'h0});
                burst = 0;
                free_cyc = cur + 3 + MEM_LAT;
            end
            if (mem_en) begin
                idx = int'(mem_addr[9:2]);
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) dev_mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    rd_word = $urandom;
                end else begin
                    rd_word = dev_mem[idx];
                end
                rd_due = cur + MEM_LAT;
                if (mem_q.size() == 0) begin
                    fail_now("unexpected_mem_en");
                end else begin
                    me = mem_q.pop_front();
                    check("mem_access", {32'(cur), 4'(mem_we), mem_be, mem_addr, mem_wdata},
                          {32'(me.cyc), 4'(me.we), me.be, me.addr, me.wdata});
                    idx = (me.addr / 4) % 256;
                    if (me.we) begin
                        for (int b = 0; b < 4; b++)
                            if (me.be[b]) model_mem[idx][8*b +: 8] = me.wdata[8*b +: 8];
                        rd = 0;
                    end else begin
                        rd = model_mem[idx];
                    end
                    resp_q.push_back('{me.cyc + 1 + MEM_LAT, me.is_d, rd});
                end
            end
            if (if_rvalid || d_rvalid) begin
                n_rv++;
                dsel = d_rvalid ? d_rdata : if_rdata;
                if (resp_q.size() == 0) begin
                    fail_now("unexpected_rvalid");
                end else begin
                    re = resp_q.pop_front();
                    check("response", {32'(cur), if_rvalid, d_rvalid, dsel},
                          {32'(re.cyc), !re.is_d, re.is_d, re.data});
                end
            end
            if (mem_q.size() > 0 && mem_q[0].cyc <= cur) begin
                fail_now("mem_en_missing");
                void'(mem_q.pop_front());
            end
            if (resp_q.size() > 0 && resp_q[0].cyc <= cur) begin
                fail_now("rvalid_missing");
                void'(resp_q.pop_front());
            end
        end
    end

    // Advance one cycle; report the grants seen in the cycle just ended.
    task automatic step(output logic gi, output logic gd);
        @(negedge CLOCK);
        gi = if_gnt;
        gd = d_gnt;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        model_mem[(addr / 4) % 256] = word;
        dev_mem[(addr / 4) % 256]   = word;
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        logic gi, gd;
        bit ok = 0;
        if_req = 1; if_addr = addr;
        for (int k = 0; k < 60 && !ok; k++) begin
            step(gi, gd);
            if (gi) ok = 1;
        end
        if_req = 0;
        if (!ok) fail_now("fetch_grant_timeout");
    endtask

    task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        logic gi, gd;
        bit ok = 0;
        d_req = 1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
        for (int k = 0; k < 60 && !ok; k++) begin
            step(gi, gd);
            if (gd) ok = 1;
        end
        d_req = 0;
        if (!ok) fail_now("data_grant_timeout");
    endtask

    task automatic idle_cycles(input int n);
        logic gi, gd;
        for (int k = 0; k < n; k++) step(gi, gd);
    endtask

    initial begin : driver
        logic gi, gd;
        string seq;
        RESET = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = $urandom;
            dev_mem[i]   = model_mem[i];
        end
        #1 RESET = 1;
        repeat (3) @(posedge CLOCK);
        #1 RESET = 0;

        // Fetch only.
        preload(32'h100, 32'h0000_0013);
        do_fetch(32'h100);
        idle_cycles(8);

        // Simultaneous store and fetch: data goes first.
        seq = "";
        d_req = 1; d_we = 1; d_be = 4'b1111; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        if_req = 1; if_addr = 32'h104;
        for (int k = 0; k < 60 && seq.len() < 2; k++) begin
            step(gi, gd);
            if (gd) begin seq = {seq, "D"}; d_req = 0; end
            if (gi) begin seq = {seq, "F"}; if_req = 0; end
        end
        if_req = 0; d_req = 0;
        n_tests++;
        if (seq != "DF") begin n_fail++; $display("FAIL simultaneous_order: got %s expected DF", seq); end
        idle_cycles(8);

        // Starvation guard: both held high continuously.
        seq = "";
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h080;
        if_req = 1; if_addr = 32'h040;
        for (int k = 0; k < 100 && seq.len() < 6; k++) begin
            step(gi, gd);
            if (gd) seq = {seq, "D"};
            if (gi) seq = {seq, "F"};
        end
        if_req = 0; d_req = 0;
        n_tests++;
        if (seq != "DDDDFD") begin n_fail++; $display("FAIL starvation_order: got %s expected DDDDFD", seq); end
        idle_cycles(8);

        // Address alignment and partial byte enables.
        do_fetch(32'h103);
        do_data(1'b1, 4'b1100, 32'h206, 32'hA5A5_5A5A);
        do_data(1'b0, 4'hF, 32'h204, 32'h0);
        idle_cycles(8);

        // Back-to-back loads.
        preload(32'h300, 32'h1111_1111);
        preload(32'h304, 32'h2222_2222);
        do_data(1'b0, 4'hF, 32'h300, 32'h0);
        do_data(1'b0, 4'hF, 32'h304, 32'h0);
        idle_cycles(8);

        // Reset while waiting on memory; then a clean fetch.
        do_fetch(32'h3F0);
        step(gi, gd);
        #1 RESET = 1;
        repeat (2) @(posedge CLOCK);
        #1 RESET = 0;
        preload(32'h0, 32'hCAFE_F00D);
        do_fetch(32'h0);
        idle_cycles(8);

        // Random traffic with dropped requests and one mid-run reset.
        gi = 0; gd = 0;
        for (int i = 0; i < 1500; i++) begin
            step(gi, gd);
            if (i == 700) begin
                RESET = 1; if_req = 0; d_req = 0;
                @(posedge CLOCK);
                #1 RESET = 0;
                gi = 0; gd = 0;
            end
            if (!if_req || gi) begin
                if_req = ($urandom_range(0, 1) == 1);
                if_addr = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                if_req = 0;
            end
            if (!d_req || gd) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = $urandom_range(0, 1);
                d_be = 4'($urandom);
                d_addr = $urandom;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                d_req = 0;
            end
        end
        if_req = 0; d_req = 0;
        idle_cycles(20);

        check("gnt_rvalid_balance", 160'(n_rv), 160'(n_gnt));
        check("queues_drained", 160'(mem_q.size() + resp_q.size()), 160'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
